// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester (CPU data port and debug/loader port) front end for a single
// pipelined memory port. One access is granted per cycle, combinationally in
// the cycle the request is presented. Conflicts are resolved round-robin. A
// debug halt removes the CPU from arbitration. Read data is routed back to
// its owner through an owner-tag pipeline matched to the memory read latency.
//
// Parameters
//   AW       address width (requesters and memory port)
//   DW       data width (requesters and memory port)
//   MEM_LAT  memory read latency in cycles, 1..4
//
// Ports
//   clk, rstn                          clock, synchronous active-low reset
//   cpu_req/we/addr/wdata   in         CPU request, held until cpu_gnt
//   cpu_gnt                 out        CPU request accepted this cycle
//   cpu_rvalid/rdata        out        CPU read return
//   dbg_req/we/addr/wdata   in         debug request, held until dbg_gnt
//   dbg_gnt                 out        debug request accepted this cycle
//   dbg_rvalid/rdata        out        debug read return
//   dbg_halt                in         blocks all CPU grants while high
//   mem_en/we/addr/wdata    out        memory access strobe and fields
//   mem_rdata               in         memory read data, MEM_LAT after strobe
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,

  input  logic          dbg_halt,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Arbitration
  logic cpuEligible;
  logic dbgEligible;
  logic grantCpu;
  logic grantDbg;
  logic lastGrantDbg;   // 1: debug port was granted most recently

  // Owner-tag pipeline: one stage per cycle of memory latency. Stage 0 is
  // loaded in the grant cycle, so the last stage lines up with mem_rdata.
  logic [MEM_LAT-1:0] tagValid;
  logic [MEM_LAT-1:0] tagDbg;
  logic               pushValid;
  logic               tagOutValid;
  logic               tagOutDbg;

  assign cpuEligible = cpu_req & ~dbg_halt;
  assign dbgEligible = dbg_req;

  // On a conflict the port that was not granted last wins. Everything is
  // masked by rstn so the block is silent while held in reset.
  assign grantCpu = rstn & cpuEligible & (~dbgEligible | lastGrantDbg);
  assign grantDbg = rstn & dbgEligible & (~cpuEligible | ~lastGrantDbg);

  assign cpu_gnt = grantCpu;
  assign dbg_gnt = grantDbg;

  // Memory port mux; idle fields are forced to zero rather than left stale.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grantCpu) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grantDbg) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Only reads carry a live tag; writes complete in their grant cycle.
  assign pushValid = (grantCpu & ~cpu_we) | (grantDbg & ~dbg_we);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lastGrantDbg <= 1'b1;
    end else if (grantCpu | grantDbg) begin
      lastGrantDbg <= grantDbg;
    end
  end

  // Reset flushes in-flight reads so nothing returns after release.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tagValid <= '0;
      tagDbg   <= '0;
    end else begin
      tagValid[0] <= pushValid;
      tagDbg[0]   <= grantDbg;
      for (int i = 1; i < MEM_LAT; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagDbg[i]   <= tagDbg[i-1];
      end
    end
  end

  assign tagOutValid = rstn & tagValid[MEM_LAT-1];
  assign tagOutDbg   = tagDbg[MEM_LAT-1];

  // Halt does not touch the tag pipeline, so CPU reads already issued
  // still return while the CPU is being held off.
  assign cpu_rvalid = tagOutValid & ~tagOutDbg;
  assign dbg_rvalid = tagOutValid &  tagOutDbg;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of both requesters and the memory port.
REQ-002 Parameter DW, default 32, data width of both requesters and the memory port.
REQ-003 Parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 cpu_req  input  1  CPU data-port request; held with its fields until cpu_gnt.
REQ-007 cpu_we  input  1  CPU request is a write (1) or read (0).
REQ-008 cpu_addr  input  AW  CPU byte address.
REQ-009 cpu_wdata  input  DW  CPU write data.
REQ-010 cpu_gnt  output  1  CPU request accepted this cycle.
REQ-011 cpu_rvalid  output  1  CPU read data valid.
REQ-012 cpu_rdata  output  DW  CPU read data.
REQ-013 dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/AW/DW  debug/loader requester, same semantics as CPU.
REQ-014 dbg_gnt, dbg_rvalid, dbg_rdata  output  1/1/DW  debug grant and read return.
REQ-015 dbg_halt  input  1  when 1, CPU requests are never granted.
REQ-016 mem_en, mem_we  output  1/1  memory access strobe and write enable.
REQ-017 mem_addr, mem_wdata  output  AW/DW  memory address and write data.
REQ-018 mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after a read strobe.

Function
REQ-019 At most one grant per cycle; cpu_gnt and dbg_gnt SHALL never both be 1.
REQ-020 Grant is combinational in the request cycle: req=1 and selected -> gnt=1, mem_en=1, mem_we/addr/wdata driven from the granted requester in the same cycle.
REQ-021 With no grant: mem_en=0, mem_we=0; mem_addr/mem_wdata SHALL hold 0.
REQ-022 Single eligible requester wins immediately; dbg_halt=1 makes CPU ineligible.
REQ-023 Both eligible: round-robin; the requester not granted most recently wins; the last-grant register updates only on a grant.
REQ-024 After reset, last-grant = DBG, so CPU wins the first conflict.
REQ-025 Fully pipelined: a new grant is allowed every cycle regardless of outstanding reads.
REQ-026 Each granted read pushes an owner tag (valid, id) into a MEM_LAT-deep shift register; writes push valid=0.
REQ-027 When a tag with valid=1 exits, the owner's rvalid=1 for exactly one cycle, and rdata = mem_rdata in that cycle.
REQ-028 The non-owner's rvalid=0; both rdata outputs SHALL be 0 when their rvalid=0.
REQ-029 Writes produce no rvalid; write completion equals the grant cycle.
REQ-030 dbg_halt asserted while CPU reads are outstanding SHALL NOT cancel them; their rvalid still returns.
REQ-031 A requester dropping req without a grant is legal; no state changes.

Reset
REQ-032 rstn=0 at a clock edge clears the tag shift register and sets last-grant=DBG.
REQ-033 While rstn=0, all outputs SHALL be 0, including grants, regardless of req inputs.
REQ-034 Reads outstanding when reset is asserted are dropped; no rvalid follows reset release.

Verification
REQ-035 MEM_LAT=1, cpu read addr 0x10, mem_rdata=0xDEADBEEF next cycle -> cpu_gnt=1 in cycle 0, mem_en=1, mem_addr=0x10; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 1; dbg_rvalid=0.
REQ-036 Both requesters reading continuously for 4 cycles after reset -> grants alternate CPU, DBG, CPU, DBG; rvalid owners follow the same order MEM_LAT cycles later.
REQ-037 dbg_halt=1, both requesting -> dbg_gnt=1 every cycle, cpu_gnt=0; dropping halt -> the next conflict goes to CPU.
REQ-038 MEM_LAT=3, back-to-back CPU read, DBG write, DBG read -> cpu_rvalid at cycle 3, nothing at cycle 4, dbg_rvalid at cycle 5.
REQ-039 CPU read granted, rstn=0 at the next edge -> no cpu_rvalid ever returns; after release, the first conflict is granted to CPU.
REQ-040 DBG write addr 0x200 data 0x12345678 -> dbg_gnt=1, mem_we=1, mem_wdata=0x12345678 in the same cycle; no rvalid follows.
